hex2char_tx: RTL
================

// Module: hex2char_tx
// PURPOSE
//   Inverse of the ASCII-hex character decoder: serialises a parallel word into ASCII hex characters.
//   Accepts one word on a valid/ready input port and emits one character per accepted output beat,
//   most-significant nibble first.
//   Feeds the console / UART character path, so a decoder at the far end reconstructs the word.
// PARAMETERS
//   NIBBLES   8   hex digits per word; legal range 1..16; in_data width = 4*NIBBLES
//   UPPER     0   0: digits 10-15 -> "a"-"f" (8'h61-8'h66); 1: -> "A"-"F" (8'h41-8'h46)
// PORTS
//   clk        in   1            rising-edge clock, single clock domain
//   rst_n      in   1            asynchronous, active-low reset
//   in_valid   in   1            in_data holds a word to send
//   in_ready   out  1            block can accept a word this cycle
//   in_data    in   4*NIBBLES    word to serialise, MSB nibble sent first
//   out_valid  out  1            out_char holds a valid character
//   out_ready  in   1            sink accepts out_char this cycle
//   out_char   out  8            ASCII character
//   out_last   out  1            out_char is the final character of the word
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, shift reg=0, cnt=0.
//     Outputs during and after reset: out_valid=0, out_last=0, out_char=8'h00, in_ready=1.
//   FSM states: IDLE, SEND (plus TERM under HEX2CHAR_TX_NEWLINE_EN).
//     IDLE: in_ready=1, out_valid=0.
//       If in_valid: latch in_data into shift reg, set cnt=NIBBLES-1, go to SEND.
//     SEND: in_ready=0, out_valid=1, out_char=ascii(shreg[top nibble]).
//       On out_valid&&out_ready with cnt!=0: shift left 4, decrement cnt.
//       On out_valid&&out_ready with cnt==0: go to IDLE (or TERM if macro enabled).
//     out_last=1 in SEND only when cnt==0 (macro off).
//   Encoding: n<10 -> 8'h30+n; n>=10 -> base+(n-10), base=8'h61 (UPPER=0) or 8'h41 (UPPER=1).
//     Computed in 8 bits, never wraps.
//   Stall: while out_ready=0, out_char/out_last/out_valid stay stable; cnt and shreg are held.
//   Latency: word accepted at edge k; first character valid in the cycle after edge k.
//   Throughput: NIBBLES beats per word + 1 IDLE bubble.
//     in_ready is never asserted in SEND, so no accept coincides with the last beat.
//   in_data is sampled only on accept; later changes to in_data are ignored.
//   When out_valid=0, out_char=8'h00 and out_last=0.
//   rst_n asserted mid-word: word is dropped, block returns to IDLE immediately, no partial resume.
//   NIBBLES=1: a single SEND beat with out_last=1.
// CONFIGURATION
//   HEX2CHAR_TX_NEWLINE_EN defined:
//     After the last digit, state TERM emits out_char=8'h0A with out_last=1.
//     out_last is 0 on all digit beats. TERM holds until out_ready, then goes to IDLE.
//     NIBBLES+1 beats per word.
//   Undefined: TERM state absent; the last digit carries out_last=1.
// TESTING
//   1. Reset, in_data=32'h1234ABCD, in_valid pulse, out_ready=1
//      -> "1","2","3","4","a","b","c","d" on consecutive cycles (8'h31..8'h64).
//      out_last only on "d"; in_ready=1 the next cycle.
//   2. UPPER=1, in_data=32'hFEDC0A09 -> 8'h46,8'h45,8'h44,8'h43,8'h30,8'h41,8'h30,8'h39.
//   3. Backpressure: out_ready low for 3 cycles on beat 2 of 32'h00000F00
//      -> out_char stays 8'h30 while stalled, no character lost or duplicated, 8 beats total.
//   4. in_valid held high with new words during SEND -> in_ready=0, ignored.
//      Second word accepted only in IDLE; in_data changes mid-send do not alter output.
//   5. rst_n pulled low during beat 4 of 32'hDEADBEEF -> out_valid=0 asynchronously.
//      After release, in_ready=1; the next word is sent from its first nibble.
//   6. With HEX2CHAR_TX_NEWLINE_EN, in_data=32'h00000001 -> 8 digits, then 8'h0A with out_last=1.
//      Round-trip each digit through the decoder gives back the original nibbles.

Source files
------------

// File: rtl/hex2char_tx.sv
// hex2char_tx: serialises a parallel word into ASCII hex characters, MSB nibble first.
// One word in on a valid/ready port, one character out per accepted beat.
// Optional HEX2CHAR_TX_NEWLINE_EN: append an 8'h0A terminator beat carrying out_last.
module hex2char_tx #(
    parameter int NIBBLES = 8,
    parameter int UPPER   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_char,
    output logic                 out_last
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(NIBBLES - 1);
    localparam logic [7:0]    ALPHA    = (UPPER != 0) ? 8'h41 : 8'h61;

`ifdef HEX2CHAR_TX_NEWLINE_EN
    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    shreg_q;
    logic [CW-1:0]   cnt_q;
    logic            load, shift;

    // nibble -> ASCII; 8-bit math, the largest result is 8'h66 so nothing wraps
    function automatic logic [7:0] ascii(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        else           return ALPHA + {4'h0, n} - 8'd10;
    endfunction

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // shift register and remaining-digit counter; only loaded on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            shreg_q <= in_data;
            cnt_q   <= CNT_INIT;
        end else if (shift) begin
            shreg_q <= shreg_q << 4;
            cnt_q   <= cnt_q - 1'b1;
        end
    end

    // next-state and output decode; in_ready only in IDLE so accept never overlaps a beat
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_char  = 8'h00;
        out_last  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                out_char  = ascii(shreg_q[W-1 -: 4]);
`ifndef HEX2CHAR_TX_NEWLINE_EN
                out_last  = (cnt_q == '0);
`endif
                if (out_ready) begin
                    if (cnt_q != '0) shift = 1'b1;
`ifdef HEX2CHAR_TX_NEWLINE_EN
                    else             state_d = TERM;
`else
                    else             state_d = IDLE;
`endif
                end
            end
`ifdef HEX2CHAR_TX_NEWLINE_EN
            TERM: begin
                out_valid = 1'b1;
                out_char  = 8'h0A;
                out_last  = 1'b1;
                if (out_ready) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

endmodule
